llsc_monitor: RTL

Memory-stage LL/SC reservation monitor and store-conditional resolver for the MIPS core. It records the address reservation created by LL and drops it on snoop hits, ERET or exception flush. It resolves each SC against that reservation: a successful SC drives one bus write via a req/ack handshake, and every SC returns a one-cycle result pulse for the rt writeback. It also produces the architectural LLbit consumed by the writeback/CP0 path.

---
 rtl/llsc_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/llsc_monitor.sv
// rtl/llsc_monitor.sv - LL/SC reservation monitor and store-conditional resolver.
// Optional reservation timeout is enabled by defining LLSC_TIMEOUT_EN.
module llsc_monitor #(
  parameter int GRAN_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        flush_cause,
  input  logic        eret,
  input  logic        ll_valid,
  input  logic [31:0] ll_addr,
  input  logic        sc_valid,
  input  logic [31:0] sc_addr,
  input  logic [31:0] sc_wdata,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        sc_done,
  output logic        sc_result,
  output logic        stall_req,
  output logic        llbit_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RESERVED = 2'd1;
  localparam logic [1:0] S_SC_WRITE = 2'd2;
  localparam logic [1:0] S_SC_RESP  = 2'd3;
  localparam int         AW         = 32 - GRAN_BITS;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] res_addr;
  logic          res_load;
  logic          sc_kill, sc_kill_nxt;
  logic [31:0]   mem_addr_nxt, mem_wdata_nxt;
  logic          sc_result_nxt;
  logic          exc_flush, clear_res, expired, res_live, snoop_hit, sc_match;
  logic          unused_low;

  assign exc_flush = flush & flush_cause;
  assign clear_res = exc_flush | eret;

`ifdef LLSC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] age_cnt;

  assign expired = (age_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      age_cnt <= '0;
    else if (res_load || state_nxt != S_RESERVED)
      age_cnt <= '0;
    else
      age_cnt <= age_cnt + 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  // An expired reservation behaves as absent for snoop and SC compares.
  assign res_live  = (state == S_RESERVED) & ~expired;
  assign snoop_hit = snoop_valid & res_live & (snoop_addr[31:GRAN_BITS] == res_addr);
  assign sc_match  = res_live & (sc_addr[31:GRAN_BITS] == res_addr);

  always_comb begin
    state_nxt     = state;
    res_load      = 1'b0;
    sc_kill_nxt   = sc_kill;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    sc_result_nxt = sc_result;
    case (state)
      S_IDLE, S_RESERVED: begin
        if (clear_res || snoop_hit) begin
          state_nxt = S_IDLE;
        end else if (sc_valid) begin
          if (sc_match) begin
            state_nxt     = S_SC_WRITE;
            mem_addr_nxt  = sc_addr;
            mem_wdata_nxt = sc_wdata;
            sc_kill_nxt   = 1'b0;
          end else begin
            state_nxt     = S_SC_RESP;
            sc_result_nxt = 1'b0;
          end
        end else if (ll_valid) begin
          state_nxt = S_RESERVED;
          res_load  = 1'b1;
        end else if (state == S_RESERVED && expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_SC_WRITE: begin
        // The bus write always completes; an exception only hides the result.
        if (exc_flush)
          sc_kill_nxt = 1'b1;
        if (mem_ack) begin
          if (sc_kill || exc_flush) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt     = S_SC_RESP;
            sc_result_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      res_addr  <= '0;
      sc_kill   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sc_result <= 1'b0;
    end else begin
      state     <= state_nxt;
      sc_kill   <= sc_kill_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      sc_result <= sc_result_nxt;
      if (res_load)
        res_addr <= ll_addr[31:GRAN_BITS];
    end
  end

  assign mem_req   = (state == S_SC_WRITE);
  assign llbit_o   = (state == S_RESERVED);
  assign sc_done   = (state == S_SC_RESP);
  assign stall_req = (sc_valid & ~sc_done) | mem_req;

  assign unused_low = ^{ll_addr[GRAN_BITS-1:0], sc_addr[GRAN_BITS-1:0], snoop_addr[GRAN_BITS-1:0]};

endmodule
